// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// Latch struct widths follow the core's 32-bit address/data bus.
package mem_arb_pkg;

  localparam int MEM_LAT_MAX = 4;
  localparam int ARB_ADDR_W  = 32;
  localparam int ARB_DATA_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPT,
    RESP
  } arb_state_e;

  typedef enum logic {
    REQ_FETCH,
    REQ_DATA
  } req_id_e;

  typedef struct packed {
    req_id_e                 id;
    logic [ARB_ADDR_W-1:0]   addr;
    logic                    we;
    logic [ARB_DATA_W/8-1:0] be;
    logic [ARB_DATA_W-1:0]   wdata;
  } lat_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch and data requesters.
// MEM_ARB_RR_EN selects strict alternation; otherwise data priority with starve guard.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_if,
  output logic grant_d
);

`ifdef MEM_ARB_RR_EN
  req_id_e last_q, last_d;

  always_comb begin
    grant_if = idle && if_valid &&
               (!d_valid || last_q == REQ_DATA);
    grant_d  = idle && d_valid && !grant_if;
    last_d   = last_q;
    if (grant_if)
      last_d = REQ_FETCH;
    else if (grant_d)
      last_d = REQ_DATA;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      last_q <= REQ_FETCH;
    else
      last_q <= last_d;
  end
`else
  logic [3:0] starve_q, starve_d;
  logic       starved;

  assign starved = starve_q >= 4'(STARVE_MAX);

  always_comb begin
    grant_if = idle && if_valid && (!d_valid || starved);
    grant_d  = idle && d_valid && !grant_if;
    starve_d = starve_q;
    if (grant_if)
      starve_d = '0;
    else if (grant_d && if_valid)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      starve_q <= '0;
    else
      starve_q <= starve_d;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, one access at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_req_we,
  input  logic [DATA_W/8-1:0] d_req_be,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int WAIT_W = $clog2(MEM_LAT_MAX);

  arb_state_e         state_q, state_d;
  lat_t               lat_q, lat_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DATA_W-1:0]  if_rsp_q, if_rsp_d;
  logic [DATA_W-1:0]  d_rsp_q, d_rsp_d;
  logic [DATA_W-1:0]  cap_data;
  logic               idle;
  logic               grant_if, grant_d;

  // No grant while reset is held, so nothing is accepted across it.
  assign idle = (state_q == IDLE) && rst;

  mem_arb_grant #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant (
    .clk     (clk),
    .rst     (rst),
    .idle    (idle),
    .if_valid(if_req_valid),
    .d_valid (d_req_valid),
    .grant_if(grant_if),
    .grant_d (grant_d)
  );

  assign cap_data = lat_q.we ? '0 : mem_rdata;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    wait_d   = wait_q;
    if_rsp_d = if_rsp_q;
    d_rsp_d  = d_rsp_q;
    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          lat_d.id    = REQ_FETCH;
          lat_d.addr  = if_req_addr;
          lat_d.we    = 1'b0;
          lat_d.be    = '1;
          lat_d.wdata = '0;
          state_d     = ISSUE;
        end else if (grant_d) begin
          lat_d.id    = REQ_DATA;
          lat_d.addr  = d_req_addr;
          lat_d.we    = d_req_we;
          lat_d.be    = d_req_be;
          lat_d.wdata = d_req_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (MEM_LAT > 1) begin
          wait_d  = WAIT_W'(MEM_LAT - 2);
          state_d = WAIT;
        end else begin
          state_d = CAPT;
        end
      end
      WAIT: begin
        if (wait_q == '0)
          state_d = CAPT;
        else
          wait_d = wait_q - 1'b1;
      end
      CAPT: begin
        if (lat_q.id == REQ_FETCH)
          if_rsp_d = cap_data;
        else
          d_rsp_d = cap_data;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      wait_q   <= '0;
      if_rsp_q <= '0;
      d_rsp_q  <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      wait_q   <= wait_d;
      if_rsp_q <= if_rsp_d;
      d_rsp_q  <= d_rsp_d;
    end
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;
  assign busy         = state_q != IDLE;

  assign mem_en    = state_q == ISSUE;
  assign mem_we    = mem_en && lat_q.we;
  assign mem_be    = mem_en ? lat_q.be : '0;
  assign mem_addr  = mem_en ? lat_q.addr : '0;
  assign mem_wdata = mem_en ? lat_q.wdata : '0;

  assign if_rsp_valid = (state_q == RESP) && (lat_q.id == REQ_FETCH);
  assign d_rsp_valid  = (state_q == RESP) && (lat_q.id == REQ_DATA);
  assign if_rsp_data  = if_rsp_q;
  assign d_rsp_data   = d_rsp_q;

endmodule
